// File: rtl/auto_pilot_if.sv
// Autopilot bundle: run controls and barrier detectors in, state, command levels/pulses and step
// count out. master = autopilot side, slave = car/controller side.
interface auto_pilot_if #(
    parameter int unsigned COUNT_W = 8
);
    logic               enable;
    logic               hand_sel;
    logic               front_detector;
    logic               back_detector;
    logic               left_detector;
    logic               right_detector;
    logic [2:0]         cur;
    logic               turn_left_signal;
    logic               turn_right_signal;
    logic               move_forward_signal;
    logic               move_backward_signal;
    logic               place_barrier_signal;
    logic               destroy_barrier_signal;
    logic [COUNT_W-1:0] move_count;

    modport master (
        input  enable, hand_sel, front_detector, back_detector, left_detector, right_detector,
        output cur, turn_left_signal, turn_right_signal, move_forward_signal,
               move_backward_signal, place_barrier_signal, destroy_barrier_signal, move_count
    );

    modport slave (
        output enable, hand_sel, front_detector, back_detector, left_detector, right_detector,
        input  cur, turn_left_signal, turn_right_signal, move_forward_signal,
               move_backward_signal, place_barrier_signal, destroy_barrier_signal, move_count
    );
endinterface

// File: rtl/auto_pilot.sv
// Wall-following maze autopilot: synchronises the four barrier detectors and sequences
// turn / move / barrier commands with programmable pulse lengths.
module auto_pilot #(
    parameter int unsigned TURN_CYCLES   = 4,
    parameter int unsigned MOVE_CYCLES   = 8,
    parameter int unsigned BACK_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter bit          MARK_DEAD_END = 1'b1,
    parameter int unsigned COUNT_W       = 8
) (
    input logic          clk,
    input logic          rst_n,
    auto_pilot_if.master bus
);
    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_LEN = max2(max2(2 * TURN_CYCLES, MOVE_CYCLES),
                                           max2(BACK_CYCLES, SETTLE_CYCLES));
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] TURN1_LAST  = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN2_LAST  = CNT_W'(2 * TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MOVE_LAST   = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACK_LAST   = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSense   = 3'd1,
        StTurn    = 3'd2,
        StForward = 3'd3,
        StBackup  = 3'd4,
        StMark    = 3'd5,
        StClear   = 3'd6,
        StSettle  = 3'd7
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   turn_last_q;
    logic               pend_fwd_q;
    logic               pend_mark_q;
    logic [3:0]         sync1_q;
    logic [3:0]         sync2_q;
    logic               front_prev_q;
    logic               tl_q, tr_q, mf_q, mb_q, pb_q, db_q;
    logic [COUNT_W-1:0] count_q;

    logic f_s, b_s, l_s, r_s;
    logic near_open, far_open, front_rise;

    // Synchronised detector order is {F, B, L, R}.
    assign f_s        = sync2_q[3];
    assign b_s        = sync2_q[2];
    assign l_s        = sync2_q[1];
    assign r_s        = sync2_q[0];
    assign near_open  = bus.hand_sel ? ~l_s : ~r_s;
    assign far_open   = bus.hand_sel ? ~r_s : ~l_s;
    // Only a new front obstacle aborts a move; a wall already ahead at SENSE does not.
    assign front_rise = f_s & ~front_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            turn_last_q  <= '0;
            pend_fwd_q   <= 1'b0;
            pend_mark_q  <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            front_prev_q <= 1'b0;
            tl_q         <= 1'b0;
            tr_q         <= 1'b0;
            mf_q         <= 1'b0;
            mb_q         <= 1'b0;
            pb_q         <= 1'b0;
            db_q         <= 1'b0;
            count_q      <= '0;
        end else begin
            sync1_q      <= {bus.front_detector, bus.back_detector,
                             bus.left_detector, bus.right_detector};
            sync2_q      <= sync1_q;
            front_prev_q <= f_s;
            // Commands default low; a state re-asserts the one it holds.
            tl_q <= 1'b0;
            tr_q <= 1'b0;
            mf_q <= 1'b0;
            mb_q <= 1'b0;
            pb_q <= 1'b0;
            db_q <= 1'b0;
            if (!bus.enable) begin
                state_q     <= StIdle;
                cnt_q       <= '0;
                pend_fwd_q  <= 1'b0;
                pend_mark_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StSense;
                        cnt_q   <= '0;
                    end
                    StSense: begin
                        cnt_q <= '0;
                        if (near_open) begin
                            state_q     <= StTurn;
                            turn_last_q <= TURN1_LAST;
                            pend_fwd_q  <= 1'b1;
                            pend_mark_q <= 1'b0;
                            tl_q        <= bus.hand_sel;
                            tr_q        <= ~bus.hand_sel;
                        end else if (!f_s) begin
                            state_q     <= StForward;
                            pend_mark_q <= 1'b0;
                            mf_q        <= 1'b1;
                        end else if (far_open) begin
                            state_q     <= StTurn;
                            turn_last_q <= TURN1_LAST;
                            pend_fwd_q  <= 1'b1;
                            pend_mark_q <= 1'b0;
                            tl_q        <= ~bus.hand_sel;
                            tr_q        <= bus.hand_sel;
                        end else if (!b_s) begin
                            state_q     <= StTurn;
                            turn_last_q <= TURN2_LAST;
                            pend_fwd_q  <= 1'b1;
                            pend_mark_q <= MARK_DEAD_END;
                            tl_q        <= bus.hand_sel;
                            tr_q        <= ~bus.hand_sel;
                        end else begin
                            state_q <= StClear;
                            db_q    <= 1'b1;
                        end
                    end
                    StTurn: begin
                        if (cnt_q == turn_last_q) begin
                            state_q <= StSettle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                            tl_q  <= tl_q;
                            tr_q  <= tr_q;
                        end
                    end
                    StForward: begin
                        if (front_rise) begin
                            cnt_q       <= '0;
                            pend_mark_q <= 1'b0;
                            if (!b_s) begin
                                state_q <= StBackup;
                                mb_q    <= 1'b1;
                            end else begin
                                state_q <= StSettle;
                            end
                        end else if (cnt_q == MOVE_LAST) begin
                            cnt_q <= '0;
                            if (count_q != '1) count_q <= count_q + COUNT_W'(1);
                            if (pend_mark_q) begin
                                state_q     <= StMark;
                                pend_mark_q <= 1'b0;
                                pb_q        <= 1'b1;
                            end else begin
                                state_q <= StSettle;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                            mf_q  <= 1'b1;
                        end
                    end
                    StBackup: begin
                        if (cnt_q == BACK_LAST) begin
                            state_q <= StSettle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                            mb_q  <= 1'b1;
                        end
                    end
                    StMark, StClear: begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                    end
                    StSettle: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q <= '0;
                            if (pend_fwd_q) begin
                                state_q    <= StForward;
                                pend_fwd_q <= 1'b0;
                                mf_q       <= 1'b1;
                            end else begin
                                state_q <= StSense;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.cur                    = state_q;
    assign bus.turn_left_signal       = tl_q;
    assign bus.turn_right_signal      = tr_q;
    assign bus.move_forward_signal    = mf_q;
    assign bus.move_backward_signal   = mb_q;
    assign bus.place_barrier_signal   = pb_q;
    assign bus.destroy_barrier_signal = db_q;
    assign bus.move_count             = count_q;
endmodule
